// File: rtl/phys_reg_file_mp.sv
// Multi-ported physical register file with per-register ready bits.
// After reset, the data array is cleared one entry per cycle before normal operation starts.
module phys_reg_file_mp #(
   parameter int WIDTH   = 1,
   parameter int NUM_WR  = 2,
   parameter int NUM_INV = 2,
   parameter int PRF_N   = 64,
   parameter int DATA_W  = 32,
   parameter int BYPASS  = 1,
   localparam int IDX_W  = $clog2(PRF_N)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_flush,
   input  logic [NUM_WR-1:0]         i_we,
   input  logic [NUM_WR*IDX_W-1:0]   i_windex,
   input  logic [NUM_WR*DATA_W-1:0]  i_wdata,
   input  logic [NUM_INV-1:0]        i_inv_en,
   input  logic [NUM_INV*IDX_W-1:0]  i_inv_index,
   input  logic [WIDTH*IDX_W-1:0]    i_rindex1,
   input  logic [WIDTH*IDX_W-1:0]    i_rindex2,
   output logic [WIDTH*DATA_W-1:0]   o_rdata1,
   output logic [WIDTH*DATA_W-1:0]   o_rdata2,
   output logic [PRF_N-1:0]          o_valid,
   output logic                      o_init_done,
   output logic                      o_dbg_state
);

   localparam logic S_INIT = 1'b0;
   localparam logic S_RUN  = 1'b1;

   logic                r_state;
   logic [IDX_W-1:0]    r_clr_cnt;
   logic [PRF_N-1:0]    r_valid;
   logic [DATA_W-1:0]   r_data [PRF_N];
   logic [PRF_N-1:0]    w_valid_nxt;
   logic                w_run;
   logic                w_wr_ok;

   assign w_run       = (r_state == S_RUN);
   // Commit writes only take effect in RUN and lose to a same-cycle reset.
   assign w_wr_ok     = w_run & ~rst;
   assign o_init_done = w_run;
   assign o_dbg_state = r_state;
   assign o_valid     = r_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_INIT;
         r_clr_cnt <= '0;
      end else if (r_state == S_INIT) begin
         r_clr_cnt <= r_clr_cnt + 1'b1;
         if (r_clr_cnt == IDX_W'(PRF_N - 1)) begin
            r_state <= S_RUN;
         end
      end
   end

   // Later ports overwrite earlier ones, so the highest-numbered port wins.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == S_INIT) begin
            r_data[r_clr_cnt] <= '0;
         end else begin
            for (int p = 0; p < NUM_WR; p++) begin
               if (i_we[p]) begin
                  r_data[i_windex[p*IDX_W +: IDX_W]] <= i_wdata[p*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   // Inv is applied after writes so it wins on a shared index.
   always_comb begin
      w_valid_nxt = r_valid;
      for (int p = 0; p < NUM_WR; p++) begin
         if (i_we[p]) begin
            w_valid_nxt[i_windex[p*IDX_W +: IDX_W]] = 1'b1;
         end
      end
      for (int q = 0; q < NUM_INV; q++) begin
         if (i_inv_en[q]) begin
            w_valid_nxt[i_inv_index[q*IDX_W +: IDX_W]] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || (r_state == S_INIT) || i_flush) begin
         r_valid <= '1;
      end else begin
         r_valid <= w_valid_nxt;
      end
   end

   always_comb begin
      o_rdata1 = '0;
      o_rdata2 = '0;
      for (int i = 0; i < WIDTH; i++) begin
         o_rdata1[i*DATA_W +: DATA_W] = r_data[i_rindex1[i*IDX_W +: IDX_W]];
         o_rdata2[i*DATA_W +: DATA_W] = r_data[i_rindex2[i*IDX_W +: IDX_W]];
         for (int p = 0; p < NUM_WR; p++) begin
            if ((BYPASS != 0) && w_wr_ok && i_we[p]) begin
               if (i_windex[p*IDX_W +: IDX_W] == i_rindex1[i*IDX_W +: IDX_W]) begin
                  o_rdata1[i*DATA_W +: DATA_W] = i_wdata[p*DATA_W +: DATA_W];
               end
               if (i_windex[p*IDX_W +: IDX_W] == i_rindex2[i*IDX_W +: IDX_W]) begin
                  o_rdata2[i*DATA_W +: DATA_W] = i_wdata[p*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_phys_reg_file_mp.sv
// Bench for phys_reg_file_mp: a reference model of the register file checked every cycle,
// plus directed scenarios with literal expectations.
module tb_phys_reg_file_mp;

   localparam int WIDTH   = 1;
   localparam int NUM_WR  = 2;
   localparam int NUM_INV = 2;
   localparam int PRF_N   = 64;
   localparam int DATA_W  = 32;
   localparam int IDX_W   = 6;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      i_flush;
   logic [NUM_WR-1:0]         i_we;
   logic [NUM_WR*IDX_W-1:0]   i_windex;
   logic [NUM_WR*DATA_W-1:0]  i_wdata;
   logic [NUM_INV-1:0]        i_inv_en;
   logic [NUM_INV*IDX_W-1:0]  i_inv_index;
   logic [WIDTH*IDX_W-1:0]    i_rindex1;
   logic [WIDTH*IDX_W-1:0]    i_rindex2;
   logic [WIDTH*DATA_W-1:0]   o_rdata1;
   logic [WIDTH*DATA_W-1:0]   o_rdata2;
   logic [PRF_N-1:0]          o_valid;
   logic                      o_init_done;
   logic                      o_dbg_state;

   phys_reg_file_mp dut (
      .clk(clk), .rst(rst), .i_flush(i_flush),
      .i_we(i_we), .i_windex(i_windex), .i_wdata(i_wdata),
      .i_inv_en(i_inv_en), .i_inv_index(i_inv_index),
      .i_rindex1(i_rindex1), .i_rindex2(i_rindex2),
      .o_rdata1(o_rdata1), .o_rdata2(o_rdata2),
      .o_valid(o_valid), .o_init_done(o_init_done), .o_dbg_state(o_dbg_state)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
   endtask

   // Reference model: data contents, ready bits, and number of non-reset cycles since reset.
   logic [DATA_W-1:0] m_data [PRF_N];
   logic [PRF_N-1:0]  m_valid;
   int                m_cyc;
   bit                m_run   = 0;
   bit                m_known = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_known = 1;
         m_run   = 0;
         m_cyc   = 0;
         m_valid = '1;
      end else if (m_known) begin
         if (!m_run) begin
            m_cyc++;
            if (m_cyc == PRF_N) begin
               m_run = 1;
               for (int i = 0; i < PRF_N; i++) m_data[i] = '0;
            end
         end else begin
            for (int p = 0; p < NUM_WR; p++)
               if (i_we[p]) m_data[i_windex[p*IDX_W +: IDX_W]] = i_wdata[p*DATA_W +: DATA_W];
            if (i_flush) begin
               m_valid = '1;
            end else begin
               for (int p = 0; p < NUM_WR; p++)
                  if (i_we[p]) m_valid[i_windex[p*IDX_W +: IDX_W]] = 1'b1;
               for (int q = 0; q < NUM_INV; q++)
                  if (i_inv_en[q]) m_valid[i_inv_index[q*IDX_W +: IDX_W]] = 1'b0;
            end
         end
      end
   end

   function automatic logic [DATA_W-1:0] exp_read(input logic [IDX_W-1:0] idx);
      logic [DATA_W-1:0] r;
      r = m_data[idx];
      for (int p = 0; p < NUM_WR; p++)
         if (i_we[p] && (i_windex[p*IDX_W +: IDX_W] == idx)) r = i_wdata[p*DATA_W +: DATA_W];
      return r;
   endfunction

   always @(negedge clk) begin
      if (m_known) begin
         chk("init_done", 64'(o_init_done), 64'(m_run));
         chk("dbg_state", 64'(o_dbg_state), 64'(m_run));
         chk("valid", 64'(o_valid), 64'(m_valid));
         if (m_run && !rst) begin
            chk("rdata1", 64'(o_rdata1), 64'(exp_read(i_rindex1)));
            chk("rdata2", 64'(o_rdata2), 64'(exp_read(i_rindex2)));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_inputs();
      i_flush = 0; i_we = '0; i_windex = '0; i_wdata = '0;
      i_inv_en = '0; i_inv_index = '0;
   endtask

   task automatic set_wr(input int p, input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] d);
      i_we[p] = 1'b1;
      i_windex[p*IDX_W +: IDX_W] = idx;
      i_wdata[p*DATA_W +: DATA_W] = d;
   endtask

   task automatic set_inv(input int q, input logic [IDX_W-1:0] idx);
      i_inv_en[q] = 1'b1;
      i_inv_index[q*IDX_W +: IDX_W] = idx;
   endtask

   initial begin
      rst = 1; clr_inputs(); i_rindex1 = '0; i_rindex2 = '0;
      tick(); tick();
      rst = 0;

      // Reset then idle: INIT for exactly 64 cycles.
      @(negedge clk);
      chk("lit_init0", 64'(o_init_done), 64'd0);
      chk("lit_valid_init", 64'(o_valid), {64{1'b1}});
      for (int k = 1; k <= PRF_N; k++) begin
         tick();
         @(negedge clk);
         if (k == 63) chk("lit_init63", 64'(o_init_done), 64'd0);
         if (k == 64) chk("lit_init64", 64'(o_init_done), 64'd1);
      end
      i_rindex1 = 6'd0; i_rindex2 = 6'd63;
      @(negedge clk);
      chk("lit_zero_p0", 64'(o_rdata1), 64'd0);
      chk("lit_zero_p63", 64'(o_rdata2), 64'd0);

      // Inv p5, then write p5 the next cycle.
      tick(); set_inv(0, 6'd5);
      tick(); clr_inputs(); set_wr(0, 6'd5, 32'hDEADBEEF); i_rindex1 = 6'd5;
      @(negedge clk);
      chk("lit_p5_invalid", 64'(o_valid[5]), 64'd0);
      chk("lit_p5_bypass", 64'(o_rdata1), 64'hDEADBEEF);
      tick(); clr_inputs();
      @(negedge clk);
      chk("lit_p5_valid", 64'(o_valid[5]), 64'd1);
      chk("lit_p5_stored", 64'(o_rdata1), 64'hDEADBEEF);

      // Two ports write p7 in the same cycle.
      tick(); set_wr(0, 6'd7, 32'h1); set_wr(1, 6'd7, 32'h2); i_rindex1 = 6'd7;
      @(negedge clk);
      chk("lit_p7_bypass", 64'(o_rdata1), 64'h2);
      tick(); clr_inputs();
      @(negedge clk);
      chk("lit_p7_stored", 64'(o_rdata1), 64'h2);

      // Inv and write p9 together.
      tick(); set_inv(1, 6'd9); set_wr(0, 6'd9, 32'h55);
      tick(); clr_inputs(); i_rindex1 = 6'd9;
      @(negedge clk);
      chk("lit_p9_invalid", 64'(o_valid[9]), 64'd0);
      chk("lit_p9_data", 64'(o_rdata1), 64'h55);

      // Inv p3/p4, then flush with a write to p3 and an inv of p6.
      tick(); set_inv(0, 6'd3); set_inv(1, 6'd4);
      tick(); clr_inputs(); i_flush = 1; set_wr(1, 6'd3, 32'h11); set_inv(0, 6'd6);
      tick(); clr_inputs(); i_rindex1 = 6'd3; i_rindex2 = 6'd6;
      @(negedge clk);
      chk("lit_flush_valid", 64'(o_valid), {64{1'b1}});
      chk("lit_flush_p3", 64'(o_rdata1), 64'h11);

      // Mixed traffic concentrated on low indices to force collisions.
      for (int c = 0; c < 40; c++) begin
         tick(); clr_inputs();
         if ($urandom_range(0, 1) == 1) set_wr(0, 6'($urandom_range(0, 15)), $urandom);
         if ($urandom_range(0, 1) == 1) set_wr(1, 6'($urandom_range(0, 15)), $urandom);
         if ($urandom_range(0, 2) == 0) set_inv(0, 6'($urandom_range(0, 15)));
         if ($urandom_range(0, 2) == 0) set_inv(1, 6'($urandom_range(0, 15)));
         i_flush   = ($urandom_range(0, 9) == 0);
         i_rindex1 = 6'($urandom_range(0, 15));
         i_rindex2 = 6'($urandom_range(0, 15));
      end

      // Reset in RUN beats flush, write and inv.
      tick(); clr_inputs(); rst = 1; i_flush = 1; set_wr(0, 6'd2, 32'h77); set_inv(0, 6'd2);
      tick(); clr_inputs(); rst = 0;
      @(negedge clk);
      chk("lit_rst_run_init", 64'(o_init_done), 64'd0);
      chk("lit_rst_run_valid", 64'(o_valid), {64{1'b1}});

      // Reset at INIT cycle 10 with writes driven throughout INIT.
      for (int k = 0; k < 10; k++) begin
         set_wr(0, 6'd1, 32'hAAAA0000 + 32'(k));
         tick();
      end
      rst = 1;
      tick();
      rst = 0;
      for (int k = 1; k <= PRF_N; k++) begin
         clr_inputs();
         set_wr(0, 6'd1, 32'hBBBB0000 + 32'(k)); set_wr(1, 6'd2, 32'hCCCC);
         set_inv(0, 6'd3); i_flush = 1'(k % 2);
         tick();
         @(negedge clk);
         if (k == 63) chk("lit_restart_init63", 64'(o_init_done), 64'd0);
      end
      clr_inputs(); i_rindex1 = 6'd1; i_rindex2 = 6'd2;
      @(negedge clk);
      chk("lit_restart_init64", 64'(o_init_done), 64'd1);
      chk("lit_restart_p1", 64'(o_rdata1), 64'd0);
      chk("lit_restart_p2", 64'(o_rdata2), 64'd0);
      chk("lit_restart_valid", 64'(o_valid), {64{1'b1}});
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
